// File: rtl/ppu_pkg.sv
// Shared PPU-side types: OAM DMA state encoding and the $4014 register address.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies one 256-byte CPU page into OAM after a $4014 write.
// Latency: 1 HALT cpu_ce (+1 ALIGN when OAM_DMA_ALIGN_EN and parity odd), then 2 cpu_ce per byte.
// Backpressure: none on input; dma_busy halts the CPU, and cpu_ce low freezes all state.
module oam_dma
    import ppu_pkg::*;
#(
    parameter logic [7:0] BASE_OAM_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic        dma_sel,
    input  logic        cpu_WE,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  mem_data_in,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    output logic [7:0]  oam_addr_out,
    output logic [7:0]  oam_data_out,
    output logic        oam_WE
);

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] index;
    logic       parity;
    logic       align_req;

`ifdef OAM_DMA_ALIGN_EN
    assign align_req = parity;
`else
    assign align_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            page         <= 8'h00;
            index        <= 8'h00;
            parity       <= 1'b0;
            dma_busy     <= 1'b0;
            dma_rd       <= 1'b0;
            oam_WE       <= 1'b0;
            dma_addr     <= 16'h0000;
            oam_data_out <= 8'h00;
            oam_addr_out <= BASE_OAM_ADDR;
        end else if (cpu_ce) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (dma_sel && cpu_WE) begin
                        page     <= cpu_data_in;
                        index    <= 8'h00;
                        dma_busy <= 1'b1;
                        state    <= HALT;
                    end
                end
                HALT: begin
                    if (align_req) begin
                        state <= ALIGN;
                    end else begin
                        dma_rd   <= 1'b1;
                        dma_addr <= {page, index};
                        state    <= READ;
                    end
                end
                ALIGN: begin
                    dma_rd   <= 1'b1;
                    dma_addr <= {page, index};
                    state    <= READ;
                end
                READ: begin
                    oam_data_out <= mem_data_in;
                    oam_addr_out <= BASE_OAM_ADDR + index;
                    dma_rd       <= 1'b0;
                    oam_WE       <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    oam_WE <= 1'b0;
                    if (index == 8'hFF) begin
                        // Last byte: release the CPU and park the address outputs.
                        dma_busy     <= 1'b0;
                        dma_addr     <= 16'h0000;
                        oam_addr_out <= BASE_OAM_ADDR;
                        state        <= IDLE;
                    end else begin
                        index    <= index + 8'd1;
                        dma_rd   <= 1'b1;
                        dma_addr <= {page, index + 8'd1};
                        state    <= READ;
                    end
                end
                default: begin
                    dma_busy     <= 1'b0;
                    dma_rd       <= 1'b0;
                    oam_WE       <= 1'b0;
                    dma_addr     <= 16'h0000;
                    oam_addr_out <= BASE_OAM_ADDR;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter: BASE_OAM_ADDR, 8'h00, OAM start offset added to the transfer index.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_ce  in  1  one-clk pulse per CPU cycle; all state advances only on clk edges with cpu_ce=1
- dma_sel  in  1  CPU is addressing $4014 this cycle
- cpu_WE  in  1  CPU write strobe
- cpu_data_in  in  8  CPU write data (source page)
- mem_data_in  in  8  CPU-bus read data returned for dma_addr
- dma_busy  out  1  halts CPU (RDY low) and gives bus to DMA
- dma_addr  out  16  CPU-bus read address
- dma_rd  out  1  DMA read cycle on CPU bus
- oam_addr_out  out  8  OAM write address
- oam_data_out  out  8  OAM write data
- oam_WE  out  1  OAM write enable

Function
REQ-003 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE; all transitions occur only on cpu_ce.
REQ-004 IDLE: on cpu_ce with dma_sel=1 and cpu_WE=1, SHALL latch page=cpu_data_in, clear index to 0, and go to HALT.
REQ-005 HALT: dma_busy=1; next cpu_ce SHALL go to ALIGN if the parity flag is 1, else READ (see REQ-013).
REQ-006 ALIGN: dma_busy=1, no bus or OAM activity; next cpu_ce SHALL go to READ.
REQ-007 READ: dma_rd=1, dma_addr={page,index}; on that cpu_ce SHALL capture mem_data_in into oam_data_out and go to WRITE.
REQ-008 WRITE: oam_WE=1 for the whole state, oam_addr_out=BASE_OAM_ADDR+index (mod 256).
REQ-009 On the WRITE cpu_ce: if index=8'hFF, SHALL go to IDLE; else increment index and go to READ.
REQ-010 dma_busy SHALL be 1 in every state except IDLE; dma_rd and oam_WE SHALL be 0 outside READ and WRITE respectively.
REQ-011 Transfer length SHALL be exactly 256 bytes: 1+512 cpu_ce cycles, or 514 with ALIGN.
REQ-012 A $4014 write while dma_busy=1 SHALL be ignored; the current transfer is unaffected.
REQ-013 A parity flag SHALL toggle on every cpu_ce (reset 0); parity is sampled on the HALT-state cpu_ce.
REQ-014 Index arithmetic SHALL be 8-bit; oam_addr_out SHALL wrap 8'hFF->8'h00 without carry into page.
REQ-015 Outputs SHALL be registered; dma_addr=16'h0000 and oam_addr_out=BASE_OAM_ADDR whenever IDLE.

Reset
REQ-016 Reset SHALL force IDLE, page=0, index=0, parity=0, dma_busy=0, dma_rd=0, oam_WE=0, dma_addr=0, oam_data_out=0, oam_addr_out=BASE_OAM_ADDR.
REQ-017 Reset asserted mid-transfer SHALL abort immediately; no further OAM writes; CPU is released.

Configuration
REQ-018 Macro OAM_DMA_ALIGN_EN: defined -> HALT enters ALIGN when parity=1 (513/514 cycles); undefined -> ALIGN is never entered, and every transfer is 513 cycles.

Structure
REQ-019 State enum (dma_state_t) and constant OAMDMA_REG_ADDR=16'h4014 SHALL live in shared package ppu_pkg.
REQ-020 Single module, no sub-modules; index counter and parity flag are inline.

Verification
REQ-021 Write 8'h02 to $4014 (parity 0), memory[i]=i^8'hA5 -> 256 oam_WE pulses; OAM[k]=k^8'hA5; dma_addr 16'h0200..16'h02FF; dma_busy high for 513 cpu_ce.
REQ-022 Same transfer started at parity 1 with OAM_DMA_ALIGN_EN -> dma_busy high for 514 cpu_ce; without the macro -> 513.
REQ-023 BASE_OAM_ADDR=8'hF0, page 8'h03 -> first write to oam_addr 8'hF0 (data mem[16'h0300]); byte 16 is written to 8'h00.
REQ-024 Second $4014 write (8'h07) at byte 100 -> ignored; all dma_addr high bytes stay 8'h02.
REQ-025 Reset asserted at byte 50 -> next clk dma_busy=0, oam_WE=0; no further writes; new $4014 write restarts at index 0.
REQ-026 cpu_ce held low for 10 clk mid-transfer -> state, dma_addr and index frozen; oam_WE held with no duplicate write.
